// File: rtl/ppe_rr_arbiter_h.sv
// ppe_rr_arbiter_h: two-level (group x member) round-robin arbiter with a
// registered grant offered on a valid/ready handshake.
//
// Build option: define PPE_RR_BURST_EN to let one requester keep up to
// MAX_BURST consecutive accepted grants while it keeps requesting.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   req        in   GROUPS*WIDTH request vector, bit g*WIDTH+i = member i of group g
//   gnt        out  registered one-hot grant, zero when gnt_valid=0
//   gnt_idx    out  registered flat index {group, member} of the offer
//   gnt_valid  out  offer valid
//   gnt_ready  in   consumer accepts the offer
//   group_req  out  combinational OR of each group's request slice
module ppe_rr_arbiter_h #(
    parameter int unsigned GROUPS    = 8,
    parameter int unsigned LOG_G     = 3,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LOG_W     = 3,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned BURST_W   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [GROUPS*WIDTH-1:0]  req,
    output logic [GROUPS*WIDTH-1:0]  gnt,
    output logic [LOG_G+LOG_W-1:0]   gnt_idx,
    output logic                     gnt_valid,
    input  logic                     gnt_ready,
    output logic [GROUPS-1:0]        group_req
);

    localparam int unsigned N     = GROUPS * WIDTH;
    localparam int unsigned IDX_W = LOG_G + LOG_W;
    localparam bit CFG_OK = (GROUPS == (32'd1 << LOG_G)) && (WIDTH == (32'd1 << LOG_W)) &&
                            (MAX_BURST >= 32'd1) && (MAX_BURST <= (32'd1 << BURST_W));

    // Parameter sanity: an inconsistent configuration elaborates this marker block.
    if (!CFG_OK) begin : g_cfg_invalid
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [LOG_G-1:0]              top_ptr_q;
    logic [GROUPS-1:0][LOG_W-1:0]  grp_ptr_q;
    logic [N-1:0]                  gnt_q, gnt_d;
    logic [IDX_W-1:0]              gnt_idx_q, gnt_idx_d;

    logic [GROUPS-1:0][WIDTH-1:0]  req_arr;
    logic [LOG_G-1:0]              cur_grp;
    logic [LOG_W-1:0]              cur_mem;
    logic                          handshake;
    logic                          burst_hold;
    logic                          advance;
    logic [LOG_G-1:0]              arb_top;
    logic [GROUPS-1:0][LOG_W-1:0]  arb_grp_ptr;
    logic                          win_any;
    logic [LOG_G-1:0]              win_grp;
    logic [LOG_W-1:0]              win_mem;
    logic [IDX_W-1:0]              win_idx;

    assign req_arr   = req;
    assign cur_grp   = gnt_idx_q[IDX_W-1:LOG_W];
    assign cur_mem   = gnt_idx_q[LOG_W-1:0];
    assign handshake = (state_q == ST_OFFER) && gnt_ready;
    assign advance   = handshake && !burst_hold;
    assign win_idx   = {win_grp, win_mem};

    // Per-group request summary
    always_comb begin : p_group_req
        group_req = '0;
        for (int unsigned g = 0; g < GROUPS; g++) begin
            group_req[g] = |req_arr[g];
        end
    end

`ifdef PPE_RR_BURST_EN
    localparam int unsigned BCW = BURST_W + 1;

    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

    // Keep the current requester while it still requests and has burst budget left
    assign burst_hold = handshake && req[gnt_idx_q] &&
                        ({1'b0, burst_cnt_q} < BCW'(MAX_BURST - 1));

    // Counter only moves on a handshake; any advance (including into IDLE) clears it
    always_comb begin : p_burst_next
        burst_cnt_d = burst_cnt_q;
        if (handshake) begin
            burst_cnt_d = burst_hold ? burst_cnt_q + BURST_W'(1) : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin : p_burst_reg
        if (rst) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    assign burst_hold = 1'b0;
`endif

    // Pointers used for this cycle's scan: already advanced past the accepted offer
    always_comb begin : p_arb_ptr
        arb_top     = top_ptr_q;
        arb_grp_ptr = grp_ptr_q;
        if (advance) begin
            arb_top              = cur_grp + LOG_G'(1);
            arb_grp_ptr[cur_grp] = cur_mem + LOG_W'(1);
        end
    end

    // Circular group scan starting at arb_top
    always_comb begin : p_grp_scan
        logic [LOG_G-1:0] g;
        g       = '0;
        win_any = 1'b0;
        win_grp = '0;
        for (int unsigned k = 0; k < GROUPS; k++) begin
            g = arb_top + LOG_G'(k);
            if (!win_any && group_req[g]) begin
                win_any = 1'b1;
                win_grp = g;
            end
        end
    end

    // Circular member scan inside the winning group
    always_comb begin : p_mem_scan
        logic [WIDTH-1:0] slice;
        logic [LOG_W-1:0] m;
        logic             found;
        slice   = req_arr[win_grp];
        m       = '0;
        found   = 1'b0;
        win_mem = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            m = arb_grp_ptr[win_grp] + LOG_W'(k);
            if (!found && slice[m]) begin
                found   = 1'b1;
                win_mem = m;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin : p_state_reg
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin : p_next_state
        state_d = state_q;
        if (state_q == ST_IDLE) begin
            if (win_any) begin
                state_d = ST_OFFER;
            end
        end else begin
            if (advance && !win_any) begin
                state_d = ST_IDLE;
            end
        end
    end

    // Offer register next values; the offer is frozen until accepted
    always_comb begin : p_output
        logic load;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        load      = 1'b0;
        if (state_q == ST_IDLE) begin
            load = win_any;
        end else if (advance) begin
            load = win_any;
            if (!win_any) begin
                gnt_d     = '0;
                gnt_idx_d = '0;
            end
        end
        if (load) begin
            gnt_d          = '0;
            gnt_d[win_idx] = 1'b1;
            gnt_idx_d      = win_idx;
        end
    end

    // Pointer and offer registers
    always_ff @(posedge clk or posedge rst) begin : p_data_reg
        if (rst) begin
            top_ptr_q <= '0;
            grp_ptr_q <= '0;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
        end else begin
            top_ptr_q <= arb_top;
            grp_ptr_q <= arb_grp_ptr;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = (state_q == ST_OFFER);

endmodule

// File: tb/tb_ppe_rr_arbiter_h.sv
// Testbench for ppe_rr_arbiter_h (GROUPS=4, WIDTH=4). Expected offers are
// queued when stimulus is driven and compared after the following clock edge.
// Build option PPE_RR_BURST_EN selects the burst-mode expectations.
module tb_ppe_rr_arbiter_h;

    localparam int unsigned GROUPS    = 4;
    localparam int unsigned LOG_G     = 2;
    localparam int unsigned WIDTH     = 4;
    localparam int unsigned LOG_W     = 2;
    localparam int unsigned MAX_BURST = 4;
    localparam int unsigned BURST_W   = 2;
    localparam int unsigned N         = GROUPS * WIDTH;
    localparam int unsigned IDX_W     = LOG_G + LOG_W;
`ifdef PPE_RR_BURST_EN
    localparam int unsigned BURST_LEN = MAX_BURST;
`else
    localparam int unsigned BURST_LEN = 1;
`endif

    typedef struct {
        logic             do_rst;
        logic [N-1:0]     req;
        logic             ready;
        logic             exp_valid;
        logic [IDX_W-1:0] exp_idx;
    } vec_t;

    typedef struct {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N-1:0]      gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_valid;
    logic              gnt_ready;
    logic [GROUPS-1:0] group_req;

    int unsigned n_run  = 0;
    int unsigned n_fail = 0;
    exp_t        sb_q[$];
    vec_t        tbl[$];

    ppe_rr_arbiter_h #(
        .GROUPS   (GROUPS),
        .LOG_G    (LOG_G),
        .WIDTH    (WIDTH),
        .LOG_W    (LOG_W),
        .MAX_BURST(MAX_BURST),
        .BURST_W  (BURST_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid),
        .gnt_ready(gnt_ready),
        .group_req(group_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [GROUPS-1:0] model_group_req(input logic [N-1:0] r);
        logic [GROUPS-1:0] res;
        res = '0;
        for (int g = 0; g < int'(GROUPS); g++) begin
            res[g] = |r[g*WIDTH +: WIDTH];
        end
        return res;
    endfunction

    // k-th offer of a full-load rotation: groups rotate fastest, members advance per lap
    function automatic logic [IDX_W-1:0] rot_idx(input int unsigned j);
        return IDX_W'((j % GROUPS) * WIDTH + (j / GROUPS) % WIDTH);
    endfunction

    function automatic void add(input logic do_rst, input logic [N-1:0] r, input logic rdy,
                                input logic ev, input logic [IDX_W-1:0] ei);
        vec_t v;
        v.do_rst    = do_rst;
        v.req       = r;
        v.ready     = rdy;
        v.exp_valid = ev;
        v.exp_idx   = ei;
        tbl.push_back(v);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},       32'(gnt),       32'd0);
        check({tag, "_gnt_valid"}, 32'(gnt_valid), 32'd0);
        check({tag, "_gnt_idx"},   32'(gnt_idx),   32'd0);
    endtask

    // Called on a falling edge; leaves reset released on the next falling edge
    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        gnt_ready = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one cycle of stimulus, queue the expected offer, compare after the edge
    task automatic drive(input string tag, input logic [N-1:0] r, input logic rdy,
                         input logic ev, input logic [IDX_W-1:0] ei);
        exp_t         e;
        logic [N-1:0] one_hot;
        req       = r;
        gnt_ready = rdy;
        e.valid   = ev;
        e.idx     = ei;
        sb_q.push_back(e);
        #1;
        check({tag, "_group_req"}, 32'(group_req), 32'(model_group_req(r)));
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        check({tag, "_gnt_valid"}, 32'(gnt_valid), 32'(e.valid));
        if (e.valid) begin
            one_hot = N'(1) << e.idx;
            check({tag, "_gnt_idx"}, 32'(gnt_idx), 32'(e.idx));
            check({tag, "_gnt"},     32'(gnt),     32'(one_hot));
        end else begin
            check({tag, "_gnt_zero"}, 32'(gnt), 32'd0);
        end
    endtask

    initial begin
        rst       = 1'b0;
        req       = '0;
        gnt_ready = 1'b0;

        // Vector table: do_rst, req, ready, exp_valid, exp_idx
        // Request drop during an offer: held at 7 until accepted, then idle
        add(1'b1, 16'h0080, 1'b0, 1'b1, 4'd7);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 4'd7);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 4'd7);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 4'd0);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 4'd0);
`ifdef PPE_RR_BURST_EN
        // Burst of MAX_BURST grants per requester
        add(1'b1, 16'h0003, 1'b1, 1'b1, 4'd0);
        add(1'b0, 16'h0003, 1'b1, 1'b1, 4'd0);
        add(1'b0, 16'h0003, 1'b1, 1'b1, 4'd0);
        add(1'b0, 16'h0003, 1'b1, 1'b1, 4'd0);
        add(1'b0, 16'h0003, 1'b1, 1'b1, 4'd1);
        add(1'b0, 16'h0003, 1'b1, 1'b1, 4'd1);
        add(1'b0, 16'h0003, 1'b1, 1'b1, 4'd1);
        add(1'b0, 16'h0003, 1'b1, 1'b1, 4'd1);
        add(1'b0, 16'h0003, 1'b1, 1'b1, 4'd0);
        // Burst cut short when the holder stops requesting
        add(1'b1, 16'h0030, 1'b0, 1'b1, 4'd4);
        add(1'b0, 16'h0030, 1'b1, 1'b1, 4'd4);
        add(1'b0, 16'h0020, 1'b1, 1'b1, 4'd5);
        add(1'b0, 16'h0020, 1'b1, 1'b1, 4'd5);
`else
        // Backpressure: offer 4 stable for five stalled cycles, then 5, then 4
        add(1'b1, 16'h0030, 1'b0, 1'b1, 4'd4);
        for (int i = 0; i < 5; i++) add(1'b0, 16'h0030, 1'b0, 1'b1, 4'd4);
        add(1'b0, 16'h0030, 1'b1, 1'b1, 4'd5);
        add(1'b0, 16'h0030, 1'b1, 1'b1, 4'd4);
        // Member pointer wrap-around in group 3
        add(1'b1, 16'h4000, 1'b0, 1'b1, 4'd14);
        add(1'b0, 16'h9000, 1'b1, 1'b1, 4'd15);
        add(1'b0, 16'h9000, 1'b1, 1'b1, 4'd12);
        add(1'b0, 16'h9000, 1'b1, 1'b1, 4'd15);
        // Non-winning groups keep their member pointer
        add(1'b1, 16'h0011, 1'b1, 1'b1, 4'd0);
        add(1'b0, 16'h0011, 1'b1, 1'b1, 4'd4);
        add(1'b0, 16'h0011, 1'b1, 1'b1, 4'd0);
        add(1'b0, 16'h0011, 1'b1, 1'b1, 4'd4);
`endif

        @(negedge clk);
        do_reset();

        // First offer one cycle after request, then a re-offer and a move to group 2
        drive("first",     16'h0001, 1'b0, 1'b1, 4'd0);
        drive("single_hs", 16'h0001, 1'b1, 1'b1, 4'd0);
        drive("move",      16'h0100, 1'b1, 1'b1, 4'd8);
        drive("hold",      16'h0100, 1'b0, 1'b1, 4'd8);

        // Asynchronous reset in the middle of an offer
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        req       = 16'h0001;
        gnt_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        drive("post_rst", 16'h0001, 1'b0, 1'b1, 4'd0);
        drive("to_idle",  16'h0000, 1'b1, 1'b0, 4'd0);

        // Full-load rotation with gnt_ready held high
        do_reset();
        for (int unsigned k = 0; k < 20; k++) begin
            drive($sformatf("rotation%0d", k), 16'hFFFF, 1'b1, 1'b1, rot_idx(k / BURST_LEN));
        end

        // Table-driven sections
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].do_rst) do_reset();
            drive($sformatf("vec%0d", i), tbl[i].req, tbl[i].ready, tbl[i].exp_valid, tbl[i].exp_idx);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
